// File: rtl/sha256_w_expander.sv
`timescale 1ns/1ps
// SHA-256 message schedule expander: latches one 512-bit block and iteratively
// expands it to W[0:63], presented as a packed vector with valid/ready.
module sha256_w_expander #(
    parameter int WORDS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              blk_valid,
    output logic              blk_ready,
    input  logic [511:0]      blk,
    output logic [0:63][31:0] W,
    output logic              w_valid,
    input  logic              w_ready
);

    if (WORDS_PER_CYCLE != 1 && WORDS_PER_CYCLE != 2 && WORDS_PER_CYCLE != 4) begin : g_bad_wpc
        $error("sha256_w_expander: WORDS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, EXPAND, HOLD} state_t;

    localparam logic [6:0] STEP   = 7'(WORDS_PER_CYCLE);
    localparam logic [6:0] LAST_T = 7'(64 - WORDS_PER_CYCLE);

    state_t      state;
    logic [6:0]  t;
    logic [5:0]  idx   [WORDS_PER_CYCLE];
    logic [31:0] chain [WORDS_PER_CYCLE + 2];

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // chain[0..1] hold W[t-2], W[t-1]; chain[j+2] is the new W[t+j], so the
    // s1 term of W[t+j] reads chain[j] whether that word is old or fresh.
    always_comb begin
        chain[0] = W[t[5:0] - 6'd2];
        chain[1] = W[t[5:0] - 6'd1];
        for (int j = 0; j < WORDS_PER_CYCLE; j++) begin
            idx[j]       = t[5:0] + 6'(j);
            chain[j + 2] = sig1(chain[j]) + W[idx[j] - 6'd7]
                         + sig0(W[idx[j] - 6'd15]) + W[idx[j] - 6'd16];
        end
    end

    assign blk_ready = (state == IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            t       <= '0;
            W       <= '0;
            w_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (blk_valid) begin
                        W[0:15] <= blk;
                        t       <= 7'd16;
                        state   <= EXPAND;
                    end
                end
                EXPAND: begin
                    for (int j = 0; j < WORDS_PER_CYCLE; j++) begin
                        W[idx[j]] <= chain[j + 2];
                    end
                    t <= t + STEP;
                    if (t == LAST_T) begin
                        state   <= HOLD;
                        w_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (w_ready) begin
                        state   <= IDLE;
                        w_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
